// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state codes, function-select codes
// and the per-state control words driven towards the datapath.
package cu_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD      = 4'd1,
      S_ADD       = 4'd2,
      S_SUB       = 4'd3,
      S_AND       = 4'd4,
      S_XOR       = 4'd5,
      S_DIV       = 4'd6,
      S_MUL       = 4'd7,
      S_PASS      = 4'd8,
      S_DONE_CALC = 4'd9,
      S_DONE_DIV  = 4'd10,
      S_DONE_MUL  = 4'd11,
      S_OUT_CALC  = 4'd12,
      S_OUT_D_M   = 4'd13
   } state_e;

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_SUB = 3'b001;
   localparam logic [2:0] F_AND = 3'b010;
   localparam logic [2:0] F_XOR = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100;
   localparam logic [2:0] F_MUL = 3'b101;

   typedef struct packed {
      logic       en_f;
      logic       en_x;
      logic       en_y;
      logic       go_calc;
      logic [1:0] op_calc;
      logic       go_div;
      logic       go_mult;
      logic       sel_h;
      logic [1:0] sel_l;
      logic       en_out_h;
      logic       en_out_l;
   } ctrl_word_t;

   // Field order: en_f en_x en_y go_calc op_calc go_div go_mult sel_h sel_l en_out_h en_out_l
   localparam ctrl_word_t CW_IDLE      = 13'b000_0_00_0_0_0_00_0_0;
   localparam ctrl_word_t CW_LOAD      = 13'b111_0_00_0_0_0_00_0_0;
   localparam ctrl_word_t CW_ADD       = 13'b000_1_00_0_0_0_00_0_0;
   localparam ctrl_word_t CW_SUB       = 13'b000_1_01_0_0_0_00_0_0;
   localparam ctrl_word_t CW_AND       = 13'b000_1_10_0_0_0_00_0_0;
   localparam ctrl_word_t CW_XOR       = 13'b000_1_11_0_0_0_00_0_0;
   localparam ctrl_word_t CW_DIV       = 13'b000_0_00_1_0_0_00_0_0;
   localparam ctrl_word_t CW_MUL       = 13'b000_0_00_0_1_0_00_0_0;
   localparam ctrl_word_t CW_PASS      = 13'b000_0_00_0_0_0_00_0_1;
   localparam ctrl_word_t CW_DONE_CALC = 13'b000_0_00_0_0_0_01_0_0;
   localparam ctrl_word_t CW_DONE_DIV  = 13'b000_0_00_0_0_1_11_0_0;
   localparam ctrl_word_t CW_DONE_MUL  = 13'b000_0_00_0_0_0_10_0_0;
   localparam ctrl_word_t CW_OUT_CALC  = 13'b000_0_00_0_0_0_00_0_1;
   localparam ctrl_word_t CW_OUT_D_M   = 13'b000_0_01_0_0_0_00_1_1;

endpackage

// File: rtl/control_unit_if.sv
// Handshake and control bundle between the control unit (master) and the
// datapath it sequences (slave).
interface control_unit_if;

   logic       go;
   logic [2:0] F;
   logic       done_calc;
   logic       done_div;
   logic       div_by_zero;
   logic       en_f;
   logic       en_x;
   logic       en_y;
   logic       go_calc;
   logic [1:0] op_calc;
   logic       go_div;
   logic       go_mult;
   logic       sel_h;
   logic [1:0] sel_l;
   logic       en_out_h;
   logic       en_out_l;
   logic       done;
   logic       errorFlag;
   logic [3:0] CS;

   modport master (
      input  go, F, done_calc, done_div, div_by_zero,
      output en_f, en_x, en_y, go_calc, op_calc, go_div, go_mult,
             sel_h, sel_l, en_out_h, en_out_l, done, errorFlag, CS
   );

   modport slave (
      output go, F, done_calc, done_div, div_by_zero,
      input  en_f, en_x, en_y, go_calc, op_calc, go_div, go_mult,
             sel_h, sel_l, en_out_h, en_out_l, done, errorFlag, CS
   );

endinterface

// File: rtl/control_unit_decode.sv
// Moore output decode: maps the current state to its control word and the
// done strobe. Unused codes decode to all-zero.
module control_unit_decode
   import cu_pkg::*;
(
   input  state_e     state,
   output ctrl_word_t cw,
   output logic       done
);

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      cw   = CW_IDLE;
      done = 1'b0;
      case (state)
         S_LOAD:      cw = CW_LOAD;
         S_ADD:       cw = CW_ADD;
         S_SUB:       cw = CW_SUB;
         S_AND:       cw = CW_AND;
         S_XOR:       cw = CW_XOR;
         S_DIV:       cw = CW_DIV;
         S_MUL:       cw = CW_MUL;
         S_PASS:      begin cw = CW_PASS;     done = 1'b1; end
         S_DONE_CALC: cw = CW_DONE_CALC;
         S_DONE_DIV:  cw = CW_DONE_DIV;
         S_DONE_MUL:  cw = CW_DONE_MUL;
         S_OUT_CALC:  begin cw = CW_OUT_CALC; done = 1'b1; end
         S_OUT_D_M:   begin cw = CW_OUT_D_M;  done = 1'b1; end
         default:     cw = CW_IDLE;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Sequencer for the ALU / divider / multiplier datapath. Define
// CU_DIV_ZERO_CHECK_EN to enable the divide-by-zero abort path and errorFlag.
module control_unit
   import cu_pkg::*;
(
   input logic            clk,
   input logic            rst,
   control_unit_if.master bus
);

   state_e     state_q, state_d;
   ctrl_word_t cw;
   logic       done;
   logic       dz_abort;

`ifdef CU_DIV_ZERO_CHECK_EN
   assign dz_abort = bus.div_by_zero &&
                     ((state_q == S_LOAD && bus.F == F_DIV) || state_q == S_DIV);
`else
   logic unused_div_by_zero;
   assign unused_div_by_zero = bus.div_by_zero;
   assign dz_abort           = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.go) state_d = S_LOAD;
         S_LOAD: begin
            case (bus.F)
               F_ADD:   state_d = S_ADD;
               F_SUB:   state_d = S_SUB;
               F_AND:   state_d = S_AND;
               F_XOR:   state_d = S_XOR;
               F_DIV:   state_d = S_DIV;
               F_MUL:   state_d = S_MUL;
               default: state_d = S_PASS;
            endcase
         end
         S_ADD, S_SUB, S_AND, S_XOR: if (bus.done_calc) state_d = S_DONE_CALC;
         S_DIV:       if (bus.done_div) state_d = S_DONE_DIV;
         S_MUL:       state_d = S_DONE_MUL;
         S_DONE_CALC: state_d = S_OUT_CALC;
         S_DONE_DIV, S_DONE_MUL: state_d = S_OUT_D_M;
         default:     state_d = S_IDLE;
      endcase
      // A zero divisor overrides both the LOAD dispatch and the DIV wait.
      if (dz_abort) state_d = S_OUT_D_M;
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

`ifdef CU_DIV_ZERO_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (dz_abort)           err_d = 1'b1;
      if (state_d == S_IDLE)  err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign bus.errorFlag = err_q;
`else
   assign bus.errorFlag = 1'b0;
`endif

   control_unit_decode u_decode (
      .state (state_q),
      .cw    (cw),
      .done  (done)
   );

   assign bus.en_f     = cw.en_f;
   assign bus.en_x     = cw.en_x;
   assign bus.en_y     = cw.en_y;
   assign bus.go_calc  = cw.go_calc;
   assign bus.op_calc  = cw.op_calc;
   assign bus.go_div   = cw.go_div;
   assign bus.go_mult  = cw.go_mult;
   assign bus.sel_h    = cw.sel_h;
   assign bus.sel_l    = cw.sel_l;
   assign bus.en_out_h = cw.en_out_h;
   assign bus.en_out_l = cw.en_out_l;
   assign bus.done     = done;
   assign bus.CS       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of single-cycle steps plus
// hand-written divide, divide-by-zero and mid-operation reset sequences.
module tb_control_unit;

   logic clk;
   logic rst;

   control_unit_if bus ();

   control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected control words, order {en_f,en_x,en_y,go_calc,op_calc,go_div,go_mult,sel_h,sel_l,en_out_h,en_out_l}
   localparam logic [12:0] W_ZERO  = 13'b000_0_00_0_0_0_00_0_0;
   localparam logic [12:0] W_LOAD  = 13'b111_0_00_0_0_0_00_0_0;
   localparam logic [12:0] W_ADD   = 13'b000_1_00_0_0_0_00_0_0;
   localparam logic [12:0] W_SUB   = 13'b000_1_01_0_0_0_00_0_0;
   localparam logic [12:0] W_AND   = 13'b000_1_10_0_0_0_00_0_0;
   localparam logic [12:0] W_XOR   = 13'b000_1_11_0_0_0_00_0_0;
   localparam logic [12:0] W_DIV   = 13'b000_0_00_1_0_0_00_0_0;
   localparam logic [12:0] W_MUL   = 13'b000_0_00_0_1_0_00_0_0;
   localparam logic [12:0] W_PASS  = 13'b000_0_00_0_0_0_00_0_1;
   localparam logic [12:0] W_DCALC = 13'b000_0_00_0_0_0_01_0_0;
   localparam logic [12:0] W_DDIV  = 13'b000_0_00_0_0_1_11_0_0;
   localparam logic [12:0] W_DMUL  = 13'b000_0_00_0_0_0_10_0_0;
   localparam logic [12:0] W_OCALC = 13'b000_0_00_0_0_0_00_0_1;
   localparam logic [12:0] W_ODM   = 13'b000_0_01_0_0_0_00_1_1;

   typedef struct {
      logic       go;
      logic [2:0] f;
      logic       dc;
      logic       dd;
      logic       dz;
      logic [3:0] cs;
      logic [12:0] cw;
      logic       dn;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t v(input logic go, input logic [2:0] f, input logic dc,
                              input logic dd, input logic dz, input logic [3:0] cs,
                              input logic [12:0] cw, input logic dn);
      vec_t r;
      r.go = go; r.f = f; r.dc = dc; r.dd = dd; r.dz = dz;
      r.cs = cs; r.cw = cw; r.dn = dn;
      return r;
   endfunction

   function automatic logic [18:0] snap();
      return {bus.CS, bus.en_f, bus.en_x, bus.en_y, bus.go_calc, bus.op_calc,
              bus.go_div, bus.go_mult, bus.sel_h, bus.sel_l, bus.en_out_h,
              bus.en_out_l, bus.done, bus.errorFlag};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got cs=%0d cw=%b done=%b err=%b, expected cs=%0d cw=%b done=%b err=%b",
                  name, act[18:15], act[14:2], act[1], act[0],
                  exp[18:15], exp[14:2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input string name, input logic go, input logic [2:0] f,
                       input logic dc, input logic dd, input logic dz,
                       input logic [3:0] cs, input logic [12:0] cw,
                       input logic dn, input logic er);
      bus.go          = go;
      bus.F           = f;
      bus.done_calc   = dc;
      bus.done_div    = dd;
      bus.div_by_zero = dz;
      @(posedge clk);
      #1;
      check(name, snap(), {cs, cw, dn, er});
   endtask

   initial begin
      rst             = 1'b0;
      bus.go          = 1'b0;
      bus.F           = 3'b000;
      bus.done_calc   = 1'b0;
      bus.done_div    = 1'b0;
      bus.div_by_zero = 1'b0;

      // ADD with stall, F changed mid-operation, go held high
      vecs.push_back(v(1, 3'd0, 1, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(1, 3'd0, 0, 0, 0, 4'd2,  W_ADD,   0));
      vecs.push_back(v(1, 3'd3, 0, 0, 0, 4'd2,  W_ADD,   0));
      vecs.push_back(v(1, 3'd3, 1, 0, 0, 4'd9,  W_DCALC, 0));
      vecs.push_back(v(1, 3'd3, 0, 0, 0, 4'd12, W_OCALC, 1));
      vecs.push_back(v(0, 3'd3, 0, 0, 0, 4'd0,  W_ZERO,  0));
      vecs.push_back(v(0, 3'd7, 1, 1, 0, 4'd0,  W_ZERO,  0));
      // SUB
      vecs.push_back(v(1, 3'd1, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(0, 3'd1, 0, 0, 0, 4'd3,  W_SUB,   0));
      vecs.push_back(v(0, 3'd1, 1, 0, 0, 4'd9,  W_DCALC, 0));
      vecs.push_back(v(0, 3'd1, 0, 0, 0, 4'd12, W_OCALC, 1));
      vecs.push_back(v(0, 3'd1, 0, 0, 0, 4'd0,  W_ZERO,  0));
      // AND
      vecs.push_back(v(1, 3'd2, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(0, 3'd2, 0, 0, 0, 4'd4,  W_AND,   0));
      vecs.push_back(v(0, 3'd2, 1, 0, 0, 4'd9,  W_DCALC, 0));
      vecs.push_back(v(0, 3'd2, 0, 0, 0, 4'd12, W_OCALC, 1));
      vecs.push_back(v(0, 3'd2, 0, 0, 0, 4'd0,  W_ZERO,  0));
      // XOR
      vecs.push_back(v(1, 3'd3, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(0, 3'd3, 0, 0, 0, 4'd5,  W_XOR,   0));
      vecs.push_back(v(0, 3'd3, 1, 0, 0, 4'd9,  W_DCALC, 0));
      vecs.push_back(v(0, 3'd3, 0, 0, 0, 4'd12, W_OCALC, 1));
      vecs.push_back(v(0, 3'd3, 0, 0, 0, 4'd0,  W_ZERO,  0));
      // PASS (111 then 110) with go held high
      vecs.push_back(v(1, 3'd7, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(1, 3'd7, 0, 0, 0, 4'd8,  W_PASS,  1));
      vecs.push_back(v(1, 3'd6, 0, 0, 0, 4'd0,  W_ZERO,  0));
      vecs.push_back(v(1, 3'd6, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(1, 3'd6, 0, 0, 0, 4'd8,  W_PASS,  1));
      vecs.push_back(v(0, 3'd6, 0, 0, 0, 4'd0,  W_ZERO,  0));
      // MUL: no done input needed; div_by_zero has no effect on a non-divide op
      vecs.push_back(v(1, 3'd5, 0, 0, 0, 4'd1,  W_LOAD,  0));
      vecs.push_back(v(1, 3'd5, 0, 0, 1, 4'd7,  W_MUL,   0));
      vecs.push_back(v(1, 3'd0, 0, 0, 0, 4'd11, W_DMUL,  0));
      vecs.push_back(v(1, 3'd0, 0, 0, 0, 4'd13, W_ODM,   1));
      vecs.push_back(v(0, 3'd0, 0, 0, 0, 4'd0,  W_ZERO,  0));

      #12;
      check("reset_state", snap(), {4'd0, W_ZERO, 1'b0, 1'b0});
      #1 rst = 1'b1;

      foreach (vecs[i])
         step($sformatf("vec%0d", i), vecs[i].go, vecs[i].f, vecs[i].dc, vecs[i].dd,
              vecs[i].dz, vecs[i].cs, vecs[i].cw, vecs[i].dn, 1'b0);

      // DIV: done_div low for five cycles in sDIV, then high
      step("div_load", 1, 3'd4, 0, 0, 0, 4'd1, W_LOAD, 0, 0);
      for (int k = 0; k < 5; k++)
         step($sformatf("div_wait%0d", k), 0, 3'd4, 0, 0, 0, 4'd6, W_DIV, 0, 0);
      step("div_ddiv", 0, 3'd4, 0, 1, 0, 4'd10, W_DDIV, 0, 0);
      step("div_out",  0, 3'd4, 0, 0, 0, 4'd13, W_ODM,  1, 0);
      step("div_idle", 0, 3'd4, 0, 0, 0, 4'd0,  W_ZERO, 0, 0);

      // Zero divisor seen in sLOAD
      step("dzl_load", 1, 3'd4, 0, 0, 0, 4'd1, W_LOAD, 0, 0);
`ifdef CU_DIV_ZERO_CHECK_EN
      step("dzl_out",  0, 3'd4, 0, 0, 1, 4'd13, W_ODM,  1, 1);
      step("dzl_idle", 0, 3'd4, 0, 0, 0, 4'd0,  W_ZERO, 0, 0);
`else
      step("dzl_div",  0, 3'd4, 0, 0, 1, 4'd6,  W_DIV,  0, 0);
      step("dzl_ddiv", 0, 3'd4, 0, 1, 1, 4'd10, W_DDIV, 0, 0);
      step("dzl_out",  0, 3'd4, 0, 0, 1, 4'd13, W_ODM,  1, 0);
      step("dzl_idle", 0, 3'd4, 0, 0, 0, 4'd0,  W_ZERO, 0, 0);
`endif

      // Zero divisor raised while waiting in sDIV, with done_div also high
      step("dzd_load", 1, 3'd4, 0, 0, 0, 4'd1, W_LOAD, 0, 0);
      step("dzd_div",  0, 3'd4, 0, 0, 0, 4'd6, W_DIV,  0, 0);
`ifdef CU_DIV_ZERO_CHECK_EN
      step("dzd_out",  0, 3'd4, 0, 1, 1, 4'd13, W_ODM,  1, 1);
      step("dzd_idle", 0, 3'd4, 0, 0, 0, 4'd0,  W_ZERO, 0, 0);
`else
      step("dzd_ddiv", 0, 3'd4, 0, 1, 1, 4'd10, W_DDIV, 0, 0);
      step("dzd_out",  0, 3'd4, 0, 0, 0, 4'd13, W_ODM,  1, 0);
      step("dzd_idle", 0, 3'd4, 0, 0, 0, 4'd0,  W_ZERO, 0, 0);
`endif

      // Asynchronous reset while stalled in sADD
      step("rst_load", 1, 3'd0, 0, 0, 0, 4'd1, W_LOAD, 0, 0);
      step("rst_add",  0, 3'd0, 0, 0, 0, 4'd2, W_ADD,  0, 0);
      #2 rst = 1'b0;
      #1 check("rst_async", snap(), {4'd0, W_ZERO, 1'b0, 1'b0});
      #2 rst = 1'b1;
      step("rst_wait", 0, 3'd0, 1, 0, 0, 4'd0, W_ZERO, 0, 0);
      step("rst_go",   1, 3'd0, 1, 0, 0, 4'd1, W_LOAD, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 go  input  1  start request, sampled only in sIDLE.
REQ-005 F  input  3  function select: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 DIV, 101 MUL, 110/111 PASS.
REQ-006 done_calc  input  1  ALU result ready.
REQ-007 done_div  input  1  divider result ready.
REQ-008 div_by_zero  input  1  divider reports zero divisor.
REQ-009 en_f, en_x, en_y  output  1 each  load enables for the F, X and Y registers.
REQ-010 go_calc  output  1  ALU start; op_calc  output  2  ALU op (00 add, 01 sub, 10 and, 11 xor).
REQ-011 go_div  output  1  divider start; go_mult  output  1  multiplier start.
REQ-012 sel_h  output  1  and sel_l  output  2  select the result mux for the high and low words.
REQ-013 en_out_h, en_out_l  output  1 each  output register load enables.
REQ-014 done  output  1  operation complete; errorFlag  output  1  divide-by-zero error.
REQ-015 CS  output  4  current state code.

Function
REQ-016 The block SHALL be a Moore FSM; all outputs are decoded from the registered state, one state per clock.
REQ-017 State codes SHALL be: sIDLE 0, sLOAD 1, sADD 2, sSUB 3, sAND 4, sXOR 5, sDIV 6, sMUL 7, sPASS 8, sDONE_CALC 9, sDONE_DIV 10, sDONE_MUL 11, sOUT_CALC 12, sOUT_D_M 13; codes 14–15 SHALL go to sIDLE.
REQ-018 Control word {en_f,en_x,en_y,go_calc,op_calc,go_div,go_mult,sel_h,sel_l,en_out_h,en_out_l} per state:
- sIDLE all 0.
- sLOAD en_f=en_x=en_y=1.
- sADD/sSUB/sAND/sXOR go_calc=1, op_calc=00/01/10/11.
- sDIV go_div=1.
- sMUL go_mult=1.
- sPASS en_out_l=1.
- sDONE_CALC sel_l=01.
- sDONE_DIV sel_h=1, sel_l=11.
- sDONE_MUL sel_l=10.
- sOUT_CALC en_out_l=1.
- sOUT_D_M op_calc=01, en_out_h=en_out_l=1.
- All unlisted fields are 0.
REQ-019 Transitions:
- sIDLE→sLOAD when go=1, else stay.
- sLOAD→state selected by F.
- sADD..sXOR→sDONE_CALC when done_calc=1, else stay.
- sDIV→sDONE_DIV when done_div=1, else stay.
- sMUL→sDONE_MUL unconditionally.
- sDONE_CALC→sOUT_CALC; sDONE_DIV, sDONE_MUL→sOUT_D_M.
- sOUT_CALC, sOUT_D_M, sPASS→sIDLE.
REQ-020 In sLOAD with F=100 and div_by_zero=1, next state SHALL be sOUT_D_M, bypassing sDIV; in sDIV with div_by_zero=1, next state SHALL be sOUT_D_M regardless of done_div.
REQ-021 errorFlag SHALL be a register set on any divide-by-zero transition into sOUT_D_M, held through that state, and cleared on entry to sIDLE.
REQ-022 done SHALL be 1 exactly in sOUT_CALC, sOUT_D_M and sPASS.
REQ-023 go SHALL be ignored outside sIDLE; F SHALL be sampled only in sLOAD.
REQ-024 Wait states SHALL stall indefinitely if their done input never asserts; only reset recovers.
REQ-025 CS SHALL equal the state register.

Reset
REQ-026 rst low SHALL immediately force sIDLE (CS=0), all control outputs 0, done=0 and errorFlag=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL abort the operation; after release the block SHALL wait in sIDLE for go.

Configuration
REQ-028 With CU_DIV_ZERO_CHECK_EN defined, REQ-020/021 SHALL apply; without it, div_by_zero SHALL be ignored, DIV always SHALL pass through sDIV→sDONE_DIV, and errorFlag SHALL be tied 0.

Structure
REQ-029 A shared package cu_pkg SHALL hold the 4-bit state codes and the 13-bit per-state control-word constants.
REQ-030 A single sub-module control_unit_decode (state→control word, done) SHALL be used; the next-state logic and registers SHALL stay in control_unit.

Verification
REQ-031 Reset, then go=1, F=000, done_calc=1 -> sLOAD, sADD (go_calc=1, op=00), sDONE_CALC (sel_l=01), sOUT_CALC (en_out_l=1, done=1), sIDLE.
REQ-032 F=100, go=1, div_by_zero=1 during sLOAD -> sLOAD, then sOUT_D_M (en_out_h=en_out_l=1, errorFlag=1), then sIDLE (errorFlag=0).
REQ-033 F=101, go=1 -> sLOAD, sMUL (go_mult=1), sDONE_MUL (sel_l=10), sOUT_D_M, sIDLE; no done input needed.
REQ-034 F=100, div_by_zero=0, done_div held 0 for 5 cycles then 1 -> CS=6 for 5 cycles, then sDONE_DIV (sel_h=1, sel_l=11), sOUT_D_M.
REQ-035 rst low during sADD -> CS=0 and all outputs 0 immediately, without a clock edge.
REQ-036 F=111, go=1 -> sLOAD, sPASS (en_out_l=1, done=1), sIDLE; go held 1 throughout the sequence has no effect outside sIDLE.
